// File: rtl/mux_scan_ctrl_pkg.sv
// Shared definitions for the mux scan controller: word/select widths,
// FSM state encoding and scan-endpoint helpers.
package mux_scan_ctrl_pkg;

   localparam int unsigned WORD_W = 8;
   localparam int unsigned SEL_W  = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SCAN = 2'd2
   } state_t;

   // First select value of a scan for the given direction.
   function automatic logic [SEL_W-1:0] sel_first(input bit descend);
      return descend ? SEL_W'(WORD_W - 1) : SEL_W'(0);
   endfunction

   // Final select value of a scan; the counter stops here instead of wrapping.
   function automatic logic [SEL_W-1:0] sel_final(input bit descend);
      return descend ? SEL_W'(0) : SEL_W'(WORD_W - 1);
   endfunction

endpackage

// File: rtl/mux_scan_ctrl_mux8to1.sv
// 8-to-1 multiplexer with enable; output forced low when disabled.
module mux8to1
   import mux_scan_ctrl_pkg::*;
(
   input  logic [SEL_W-1:0] W,
   input  logic             I [0:WORD_W-1],
   input  logic             En,
   output logic             f
);

   always_comb begin
      f = 1'b0;
      if (En) begin
         f = I[W];
      end
   end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Serializes a captured 8-bit word through an 8-to-1 mux, one bit per cycle,
// in ascending or descending select order.
module mux_scan_ctrl
   import mux_scan_ctrl_pkg::*;
#(
   parameter bit DESCEND = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [WORD_W-1:0] data_in,
   output logic [SEL_W-1:0]  sel,
   output logic              en,
   output logic              sout,
   output logic              valid,
   output logic              last,
   output logic              busy,
   output logic              done
);

   localparam logic [SEL_W-1:0] SEL_FIRST = sel_first(DESCEND);
   localparam logic [SEL_W-1:0] SEL_FINAL = sel_final(DESCEND);

   state_t             state,     state_nxt;
   logic [SEL_W-1:0]   cnt,       cnt_nxt;
   logic [WORD_W-1:0]  held,      held_nxt;
   logic [SEL_W-1:0]   sel_nxt;
   logic               en_nxt;
   logic               valid_nxt;
   logic               last_nxt;
   logic               busy_nxt;
   logic               done_nxt;
   logic               mux_in [0:WORD_W-1];

   // State, counter, holding register and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         held  <= '0;
         sel   <= '0;
         en    <= 1'b0;
         valid <= 1'b0;
         last  <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         held  <= held_nxt;
         sel   <= sel_nxt;
         en    <= en_nxt;
         valid <= valid_nxt;
         last  <= last_nxt;
         busy  <= busy_nxt;
         done  <= done_nxt;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      held_nxt  = held;
      done_nxt  = 1'b0;

      unique case (state)
         IDLE: begin
            if (start) begin
               held_nxt  = data_in;
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            if (abort) begin
               state_nxt = IDLE;
            end else begin
               cnt_nxt   = SEL_FIRST;
               state_nxt = SCAN;
            end
         end
         SCAN: begin
            if (abort) begin
               state_nxt = IDLE;
            end else if (cnt == SEL_FINAL) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end else begin
               cnt_nxt = DESCEND ? cnt - SEL_W'(1) : cnt + SEL_W'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      // Outputs describe the state being entered, so they line up with it.
      en_nxt    = (state_nxt == SCAN);
      valid_nxt = en_nxt;
      busy_nxt  = (state_nxt != IDLE);
      last_nxt  = en_nxt && (cnt_nxt == SEL_FINAL);
      sel_nxt   = en_nxt ? cnt_nxt : sel;
   end

   // Mux input k carries bit k of the captured word.
   always_comb begin
      for (int k = 0; k < WORD_W; k++) begin
         mux_in[k] = held[k];
      end
   end

   mux8to1 u_mux (
      .W  (sel),
      .I  (mux_in),
      .En (en),
      .f  (sout)
   );

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed self-checking bench for mux_scan_ctrl (ascending and descending instances).
module tb_mux_scan_ctrl;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       abort;
   logic [7:0] data_in;

   logic [2:0] d0_sel, d1_sel;
   logic       d0_en, d0_sout, d0_valid, d0_last, d0_busy, d0_done;
   logic       d1_en, d1_sout, d1_valid, d1_last, d1_busy, d1_done;

   int n_checks = 0;
   int n_pass   = 0;

   mux_scan_ctrl #(.DESCEND(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .data_in(data_in),
      .sel(d0_sel), .en(d0_en), .sout(d0_sout), .valid(d0_valid),
      .last(d0_last), .busy(d0_busy), .done(d0_done)
   );

   mux_scan_ctrl #(.DESCEND(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .data_in(data_in),
      .sel(d1_sel), .en(d1_en), .sout(d1_sout), .valid(d1_valid),
      .last(d1_last), .busy(d1_busy), .done(d1_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [17:0] obs;
      rst_n   = 1'b0;
      start   = 1'b0;
      abort   = 1'b0;
      data_in = 8'h00;
      #12;
      obs = {d0_sel, d0_en, d0_sout, d0_valid, d0_last, d0_busy, d0_done,
             d1_sel, d1_en, d1_sout, d1_valid, d1_last, d1_busy, d1_done};
      n_checks++;
      if (obs !== 18'h0) $display("FAIL reset_outputs got %h want 0", obs);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      n_checks++;
      if ({d0_busy, d0_en, d0_done} !== 3'b000)
         $display("FAIL reset_idle got %b want 000", {d0_busy, d0_en, d0_done});
      else n_pass++;
   endtask

   task automatic test_ascend();
      logic [7:0] seq;
      seq     = 8'b0000_0111;   // seq[i] = i-th sout: 1,1,1,0,0,0,0,0
      data_in = 8'b0000_0111;
      start   = 1'b1;
      tick();
      start   = 1'b0;
      n_checks++;
      if ({d0_busy, d0_en, d0_valid, d0_sout} !== 4'b1000)
         $display("FAIL asc_load got %b want 1000", {d0_busy, d0_en, d0_valid, d0_sout});
      else n_pass++;
      for (int i = 0; i < 8; i++) begin
         tick();
         n_checks++;
         if ({d0_sel, d0_sout, d0_en, d0_valid, d0_last, d0_done} !==
             {3'(i), seq[i], 1'b1, 1'b1, (i == 7), 1'b0})
            $display("FAIL asc_scan[%0d] got sel=%0d sout=%b en=%b v=%b l=%b d=%b want sel=%0d sout=%b",
                     i, d0_sel, d0_sout, d0_en, d0_valid, d0_last, d0_done, i, seq[i]);
         else n_pass++;
      end
      tick();
      n_checks++;
      if ({d0_done, d0_busy, d0_valid, d0_en, d0_last, d0_sout, d0_sel} !== {6'b100000, 3'd7})
         $display("FAIL asc_done got d=%b b=%b v=%b sel=%0d want d=1 b=0 v=0 sel=7",
                  d0_done, d0_busy, d0_valid, d0_sel);
      else n_pass++;
      tick();
      n_checks++;
      if (d0_done !== 1'b0) $display("FAIL asc_done_pulse got %b want 0", d0_done);
      else n_pass++;
   endtask

   task automatic test_descend();
      logic [7:0] seq;
      seq     = 8'b1010_0101;   // seq[i] = i-th sout: 1,0,1,0,0,1,0,1
      data_in = 8'hA5;
      start   = 1'b1;
      tick();
      start   = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         n_checks++;
         if ({d1_sel, d1_sout, d1_valid, d1_last} !== {3'(7 - i), seq[i], 1'b1, (i == 7)})
            $display("FAIL desc_scan[%0d] got sel=%0d sout=%b v=%b l=%b want sel=%0d sout=%b",
                     i, d1_sel, d1_sout, d1_valid, d1_last, 7 - i, seq[i]);
         else n_pass++;
      end
      tick();
      n_checks++;
      if ({d1_done, d1_busy, d1_sel} !== {2'b10, 3'd0})
         $display("FAIL desc_done got d=%b b=%b sel=%0d want d=1 b=0 sel=0", d1_done, d1_busy, d1_sel);
      else n_pass++;
      tick();
   endtask

   task automatic test_isolation();
      logic [7:0] seq;
      seq     = 8'h3C;          // 0,0,1,1,1,1,0,0
      data_in = 8'h3C;
      start   = 1'b1;
      tick();
      start   = 1'b0;
      data_in = 8'hFF;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (i == 2) start = 1'b1;
         if (i == 4) start = 1'b0;
         n_checks++;
         if ({d0_sel, d0_sout} !== {3'(i), seq[i]})
            $display("FAIL iso_scan[%0d] got sel=%0d sout=%b want sel=%0d sout=%b",
                     i, d0_sel, d0_sout, i, seq[i]);
         else n_pass++;
      end
      tick();
      n_checks++;
      if ({d0_done, d0_busy} !== 2'b10)
         $display("FAIL iso_done got d=%b b=%b want d=1 b=0", d0_done, d0_busy);
      else n_pass++;
      tick();
      n_checks++;
      if ({d0_done, d0_busy} !== 2'b00)
         $display("FAIL iso_no_restart got d=%b b=%b want 00", d0_done, d0_busy);
      else n_pass++;
   endtask

   task automatic test_abort();
      logic [7:0] seq;
      seq     = 8'hF0;
      data_in = 8'hF0;
      start   = 1'b1;
      tick();
      start   = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_checks++;
         if ({d0_sel, d0_sout, d0_valid} !== {3'(i), seq[i], 1'b1})
            $display("FAIL abort_pre[%0d] got sel=%0d sout=%b v=%b want sel=%0d sout=%b v=1",
                     i, d0_sel, d0_sout, d0_valid, i, seq[i]);
         else n_pass++;
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      n_checks++;
      if ({d0_en, d0_valid, d0_last, d0_busy, d0_done, d0_sout, d0_sel} !== {6'b000000, 3'd3})
         $display("FAIL abort_idle got en=%b v=%b l=%b b=%b d=%b s=%b sel=%0d want all 0 sel=3",
                  d0_en, d0_valid, d0_last, d0_busy, d0_done, d0_sout, d0_sel);
      else n_pass++;
      for (int i = 0; i < 6; i++) begin
         tick();
         n_checks++;
         if ({d0_done, d0_last, d0_busy} !== 3'b000)
            $display("FAIL abort_quiet[%0d] got d=%b l=%b b=%b want 000", i, d0_done, d0_last, d0_busy);
         else n_pass++;
      end
      // start and abort together in IDLE: start wins
      seq     = 8'h81;
      data_in = 8'h81;
      start   = 1'b1;
      abort   = 1'b1;
      tick();
      start   = 1'b0;
      abort   = 1'b0;
      n_checks++;
      if ({d0_busy, d0_en} !== 2'b10)
         $display("FAIL abort_start_wins got b=%b en=%b want b=1 en=0", d0_busy, d0_en);
      else n_pass++;
      for (int i = 0; i < 8; i++) begin
         tick();
         n_checks++;
         if ({d0_sel, d0_sout, d0_last} !== {3'(i), seq[i], (i == 7)})
            $display("FAIL abort_rescan[%0d] got sel=%0d sout=%b l=%b want sel=%0d sout=%b",
                     i, d0_sel, d0_sout, d0_last, i, seq[i]);
         else n_pass++;
      end
      tick();
      n_checks++;
      if (d0_done !== 1'b1) $display("FAIL abort_rescan_done got %b want 1", d0_done);
      else n_pass++;
      tick();
   endtask

   task automatic test_async_reset();
      data_in = 8'hFF;
      start   = 1'b1;
      tick();
      start   = 1'b0;
      repeat (3) tick();
      n_checks++;
      if ({d0_sel, d0_sout, d0_en} !== {3'd2, 2'b11})
         $display("FAIL areset_pre got sel=%0d sout=%b en=%b want sel=2 sout=1 en=1",
                  d0_sel, d0_sout, d0_en);
      else n_pass++;
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({d0_sel, d0_en, d0_sout, d0_valid, d0_last, d0_busy, d0_done} !== 9'h0)
         $display("FAIL areset_now got %b want 0",
                  {d0_sel, d0_en, d0_sout, d0_valid, d0_last, d0_busy, d0_done});
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         n_checks++;
         if ({d0_done, d0_busy, d0_valid} !== 3'b000)
            $display("FAIL areset_after[%0d] got d=%b b=%b v=%b want 000", i, d0_done, d0_busy, d0_valid);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      int ph;
      data_in = 8'h01;
      start   = 1'b1;
      tick();
      for (int k = 0; k < 30; k++) begin
         ph = k % 10;
         n_checks++;
         if (ph == 0) begin
            if ({d0_busy, d0_en, d0_done} !== 3'b100)
               $display("FAIL b2b_load[%0d] got b=%b en=%b d=%b want 100", k, d0_busy, d0_en, d0_done);
            else n_pass++;
         end else if (ph == 9) begin
            if ({d0_busy, d0_en, d0_done} !== 3'b001)
               $display("FAIL b2b_done[%0d] got b=%b en=%b d=%b want 001", k, d0_busy, d0_en, d0_done);
            else n_pass++;
         end else begin
            if ({d0_en, d0_sel, d0_last, d0_sout} !== {1'b1, 3'(ph - 1), (ph == 8), (ph == 1)})
               $display("FAIL b2b_scan[%0d] got en=%b sel=%0d l=%b s=%b want en=1 sel=%0d",
                        k, d0_en, d0_sel, d0_last, d0_sout, ph - 1);
            else n_pass++;
         end
         tick();
      end
      start = 1'b0;
      repeat (10) tick();
      n_checks++;
      if ({d0_done, d0_busy} !== 2'b00)
         $display("FAIL b2b_drain got d=%b b=%b want 00", d0_done, d0_busy);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_ascend();
      test_descend();
      test_isolation();
      test_abort();
      test_async_reset();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got running want finished");
      $fatal(1);
   end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 The block SHALL have exactly one parameter: DESCEND, default 0, scan order (0: sel 0->7, 1: sel 7->0).
REQ-002 The port clk SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-003 The port rst_n SHALL be an input, 1 bit wide: reset, asynchronous, active-low.
REQ-004 The port start SHALL be an input, 1 bit wide: request to serialize data_in, sampled only in IDLE.
REQ-005 The port abort SHALL be an input, 1 bit wide: synchronous cancel of an active scan.
REQ-006 The port data_in SHALL be an input, 8 bits wide: parallel word to scan; bit k is mux input k.
REQ-007 The port sel SHALL be an output, 3 bits wide: current mux select W.
REQ-008 The port en SHALL be an output, 1 bit wide: mux enable, high only in SCAN.
REQ-009 The port sout SHALL be an output, 1 bit wide: mux output f, the currently selected bit of the captured word.
REQ-010 The port valid SHALL be an output, 1 bit wide: sout is a scan bit this cycle.
REQ-011 The port last SHALL be an output, 1 bit wide: high with valid on the final (8th) bit.
REQ-012 The port busy SHALL be an output, 1 bit wide: high in LOAD and SCAN.
REQ-013 The port done SHALL be an output, 1 bit wide: one-cycle pulse after a completed, non-aborted scan.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, LOAD and SCAN.
REQ-015 In IDLE with start=1 at a clock edge, the block SHALL capture data_in into an 8-bit holding register and enter LOAD.
REQ-016 LOAD SHALL last exactly one cycle; it SHALL preset the select counter to 0 (DESCEND=0) or 7 (DESCEND=1), then enter SCAN.
REQ-017 In SCAN, en=1 and valid=1; sel SHALL equal the counter; sout SHALL equal held[sel] through the mux (combinational, zero added latency).
REQ-018 The counter SHALL advance by +1 (DESCEND=0) or -1 (DESCEND=1) each SCAN cycle; SCAN SHALL last exactly 8 cycles.
REQ-019 last SHALL be 1 when the counter is 7 (DESCEND=0) or 0 (DESCEND=1); in that cycle the counter SHALL NOT wrap, and the FSM SHALL return to IDLE.
REQ-020 done SHALL be 1 in the first IDLE cycle after a complete scan; total latency from the start edge to done is 10 cycles.
REQ-021 start SHALL be ignored in LOAD and SCAN, and changes to data_in after capture SHALL NOT affect sout.
REQ-022 abort=1 in LOAD or SCAN SHALL force IDLE on the next edge, with no done pulse and no last pulse; abort in IDLE SHALL have no effect.
REQ-023 If abort and start are both high in IDLE, start SHALL win.
REQ-024 Back-to-back operation: start high in the done cycle SHALL be accepted, giving one idle gap cycle between scans.
REQ-025 Outside SCAN: en=0, valid=0, last=0, and sel holds its last value; sout SHALL be 0 because the mux is disabled.

Reset
REQ-026 On rst_n=0, immediately and independent of clk: state=IDLE, counter=0, held=8'h00, sel=0, en=0, valid=0, last=0, busy=0, done=0, sout=0.
REQ-027 Reset asserted mid-scan SHALL discard the scan with no done pulse; after release the block SHALL wait for a new start.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding (2 bits: IDLE, LOAD, SCAN) and the constants WORD_W=8 and SEL_W=3.
REQ-029 The block SHALL instantiate exactly one sub-module, mux8to1 (ports W[2:0], I[0:7], En, f; f = En ? I[W] : 0), fed by held, sel and en.
REQ-030 No other datapath logic SHALL drive sout.

Verification
REQ-031 Scan of data_in=8'b00000111 with DESCEND=0: start -> sel 0..7 on consecutive cycles, sout=1,1,1,0,0,0,0,0, last on sel=7, done 10 cycles after start.
REQ-032 DESCEND=1 with data_in=8'hA5: sout=1,0,1,0,0,1,0,1 for sel 7..0.
REQ-033 Capture isolation: data_in changes to 8'hFF during SCAN -> the sout sequence still matches the captured word, and a second start while busy is ignored.
REQ-034 Abort at the 4th SCAN cycle -> IDLE next edge, valid=0, no done and no last; a following scan completes normally.
REQ-035 rst_n pulsed low mid-cycle during SCAN -> all outputs 0 immediately without a clock edge; no done after release.
REQ-036 start held high continuously -> scans repeat with done and a new LOAD in the same cycle, 10-cycle period.
